uart_line_status_irq: RTL and testbench
=======================================

Name: uart_line_status_irq

Overview:
Parametrised successor to the UART line status register. It holds live FIFO status, sticky clear-on-read receive error flags, overrun detection, and a saturating receive-error counter. It adds an interrupt enable register and a prioritised interrupt identification register that drive a registered irq line. It sits on the UART register bus beside the TX/RX FIFOs and the receiver framing logic.

Parameters:
ADDR_W, 16, register bus address width
IER_ADDR, 16'h0001, interrupt enable register address (R/W)
IIR_ADDR, 16'h0002, interrupt identification register address (RO)
LSR_ADDR, 16'h0004, line status register address (RO, clear-on-read)
ESR_ADDR, 16'h0005, error status/count register address (read; any write clears)
ERR_CNT_W, 7, error counter width, legal range 1..7

Ports:
m_clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  ADDR_W  register address
rd_en  in  1  read strobe, one cycle per access
wr_en  in  1  write strobe, one cycle per access
data_in  in  8  write data
data_out_reg  out  8  registered read data
FIFO_EN  in  1  FIFO mode enabled (live)
wr_full_tx  in  1  TX FIFO full (live)
wr_full_RX  in  1  RX FIFO full (live)
rd_empty_RX  in  1  RX FIFO empty (live)
trigger_RX  in  1  RX FIFO at trigger level (live)
rx_push  in  1  one-cycle strobe: received character written to RX FIFO
start_bit_error  in  1  error flag, qualified by rx_push
parity_bit_error  in  1  error flag, qualified by rx_push
framing_stop_error  in  1  error flag, qualified by rx_push
irq  out  1  registered interrupt request, active-high

Behaviour:
- Reset (synchronous, active-high): data_out_reg=8'h00, irq=0, IER=3'b000, all sticky flags=0, error count=0.
- LSR layout: [0] FIFO_EN, [1] wr_full_tx, [2] rd_empty_RX, [3] wr_full_RX, [4] trigger_RX. These bits are live. [5] framing, [6] parity, [7] start. Bits 5-7 are sticky.
- Sticky set: bit is set on any cycle where rx_push=1 and the matching error input=1. Error inputs are ignored when rx_push=0.
- Overrun: sticky flag set when rx_push=1 and wr_full_RX=1 in the same cycle.
- Error counter: increments by 1 on rx_push with any of the three errors or an overrun. Saturates at 2^ERR_CNT_W-1 with no wrap.
- Reads: rd_en=1 with a matching address loads data_out_reg at that edge, so data is valid the cycle after the strobe. Without a matching read, data_out_reg holds its value. An unmapped address leaves data_out_reg unchanged.
- IER read: {5'b0, IER[2:0]}. IIR read: {5'b0, code}. ESR read: {count zero-extended to 7 bits, overrun}.
- LSR read clears bits 5-7. The returned value is the pre-clear value OR any same-cycle new event. If a new event coincides with the clearing read, the bit stays set after the read (set wins).
- ESR write (wr_en, any data) clears the count and the overrun flag. A same-cycle error event is applied after the clear, giving count=1 and overrun per the event. ESR read does not clear.
- IER write: IER <= data_in[2:0]. Writes to LSR and IIR are ignored.
- Interrupt sources:
  - LS = IER[2] & (any sticky error | overrun)
  - RXD = IER[0] & (FIFO_EN ? trigger_RX : ~rd_empty_RX)
  - TXR = IER[1] & ~wr_full_tx
- IIR code priority: LS 3'b110 > RXD 3'b100 > TXR 3'b010 > none 3'b001.
- irq is registered: irq <= (code != 3'b001). It therefore lags the source by one cycle. Sources are level-based and cleared only by removing the cause.
- rd_en and wr_en asserted together on the same address: the write is applied and the read returns the pre-write value.
- Reset asserted mid-access overrides everything.

Test Plan:
1. Reset → data_out_reg=8'h00, irq=0. A read of IER then returns 8'h00.
2. FIFO_EN=1, wr_full_tx=1, rd_empty_RX=0, wr_full_RX=0, trigger_RX=1, no errors; read LSR → data_out_reg=8'h13 one cycle after rd_en.
3. rx_push with parity_bit_error=1 → LSR read returns bit6=1, second LSR read returns bit6=0. Parity asserted with rx_push=0 → no set.
4. IER=3'b100, framing error pushed → irq rises 1 cycle later; IIR reads 8'h06; LSR read → irq falls 1 cycle after the clear.
5. IER=3'b111, TX not full, RX trigger, framing error pending → IIR=8'h06. After LSR read → IIR=8'h04. After trigger_RX=0 with FIFO_EN=1 → IIR=8'h02.
6. ERR_CNT_W=2, five error pushes → ESR=8'h06; push with wr_full_RX=1 → ESR=8'h07. ESR write coincident with an error push → ESR=8'h02 (overrun clear, count 1).

Source files
------------

// File: rtl/uart_line_status_irq.sv
// -----------------------------------------------------------------------------
// uart_line_status_irq
//
// UART line status block. It provides:
//   - LSR  : live FIFO status bits plus sticky receive-error flags that clear
//            when the register is read
//   - ESR  : overrun flag and a saturating receive-error counter, cleared by
//            any write
//   - IER  : 3-bit interrupt enable register (LS / TXR / RXD)
//   - IIR  : prioritised interrupt identification code
//   - irq  : registered interrupt request
//
// Ports:
//   m_clk, reset         clock, synchronous active-high reset
//   address, rd_en,      register bus: one-cycle strobes; read data appears
//   wr_en, data_in,      on data_out_reg the cycle after rd_en
//   data_out_reg
//   FIFO_EN, wr_full_tx, live FIFO status inputs
//   wr_full_RX,
//   rd_empty_RX,
//   trigger_RX
//   rx_push              strobe: received character written to the RX FIFO
//   start_bit_error,     receive error flags, meaningful only with rx_push
//   parity_bit_error,
//   framing_stop_error
//   irq                  active-high interrupt request
//
// ERR_CNT_W must be in the range 1..7 so the count fits the ESR layout.
// -----------------------------------------------------------------------------
module uart_line_status_irq #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] IER_ADDR  = 16'h0001,
  parameter logic [ADDR_W-1:0] IIR_ADDR  = 16'h0002,
  parameter logic [ADDR_W-1:0] LSR_ADDR  = 16'h0004,
  parameter logic [ADDR_W-1:0] ESR_ADDR  = 16'h0005,
  parameter int unsigned       ERR_CNT_W = 7
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out_reg,
  input  logic              FIFO_EN,
  input  logic              wr_full_tx,
  input  logic              wr_full_RX,
  input  logic              rd_empty_RX,
  input  logic              trigger_RX,
  input  logic              rx_push,
  input  logic              start_bit_error,
  input  logic              parity_bit_error,
  input  logic              framing_stop_error,
  output logic              irq
);

  typedef enum logic [2:0] {
    IIR_NONE = 3'b001,
    IIR_TXR  = 3'b010,
    IIR_RXD  = 3'b100,
    IIR_LS   = 3'b110
  } iir_code_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  logic [2:0]           r_ier;
  logic                 r_err_framing;
  logic                 r_err_parity;
  logic                 r_err_start;
  logic                 r_overrun;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_lsr_rd;
  logic                 w_esr_wr;
  logic                 w_ier_wr;
  logic                 w_ev_framing;
  logic                 w_ev_parity;
  logic                 w_ev_start;
  logic                 w_ev_overrun;
  logic                 w_ev_any;
  logic [7:0]           w_lsr_value;
  logic [6:0]           w_cnt_ext;
  logic [ERR_CNT_W-1:0] w_cnt_base;
  logic [ERR_CNT_W-1:0] w_cnt_next;
  logic                 w_src_ls;
  logic                 w_src_rxd;
  logic                 w_src_txr;
  iir_code_t            w_iir_code;
  logic                 w_rd_hit;
  logic [7:0]           w_rd_data;
  logic                 w_unused_data;

  // Only the low three bits of write data are ever stored.
  assign w_unused_data = ^data_in[7:3];

  assign w_lsr_rd = rd_en & (address == LSR_ADDR);
  assign w_esr_wr = wr_en & (address == ESR_ADDR);
  assign w_ier_wr = wr_en & (address == IER_ADDR);

  // Error inputs only count when a character is actually pushed.
  assign w_ev_framing = rx_push & framing_stop_error;
  assign w_ev_parity  = rx_push & parity_bit_error;
  assign w_ev_start   = rx_push & start_bit_error;
  assign w_ev_overrun = rx_push & wr_full_RX;
  assign w_ev_any     = w_ev_framing | w_ev_parity | w_ev_start | w_ev_overrun;

  // A read that coincides with a new event must still report that event,
  // otherwise it would be cleared without software ever seeing it.
  assign w_lsr_value = {r_err_start   | w_ev_start,
                        r_err_parity  | w_ev_parity,
                        r_err_framing | w_ev_framing,
                        trigger_RX, wr_full_RX, rd_empty_RX, wr_full_tx, FIFO_EN};

  assign w_cnt_ext = 7'(r_err_cnt);

  // The ESR clear is applied first so a same-cycle error counts from zero.
  assign w_cnt_base = w_esr_wr ? '0 : r_err_cnt;
  assign w_cnt_next = (w_ev_any && (w_cnt_base != CNT_MAX)) ? (w_cnt_base + CNT_ONE)
                                                            : w_cnt_base;

  assign w_src_ls  = r_ier[2] & (r_err_framing | r_err_parity | r_err_start | r_overrun);
  assign w_src_rxd = r_ier[0] & (FIFO_EN ? trigger_RX : ~rd_empty_RX);
  assign w_src_txr = r_ier[1] & ~wr_full_tx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_iir_code = IIR_NONE;
    if (w_src_ls)       w_iir_code = IIR_LS;
    else if (w_src_rxd) w_iir_code = IIR_RXD;
    else if (w_src_txr) w_iir_code = IIR_TXR;
  end

  always_comb begin
    w_rd_hit  = 1'b1;
    w_rd_data = 8'h00;
    if (address == IER_ADDR)      w_rd_data = {5'b0_0000, r_ier};
    else if (address == IIR_ADDR) w_rd_data = {5'b0_0000, w_iir_code};
    else if (address == LSR_ADDR) w_rd_data = w_lsr_value;
    else if (address == ESR_ADDR) w_rd_data = {w_cnt_ext, r_overrun};
    else                          w_rd_hit  = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; this is what lets a combined read/write return
  // the old contents.
  always_ff @(posedge m_clk) begin
    if (reset) begin
      data_out_reg  <= 8'h00;
      irq           <= 1'b0;
      r_ier         <= 3'b000;
      r_err_framing <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_start   <= 1'b0;
      r_overrun     <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      if (rd_en && w_rd_hit) data_out_reg <= w_rd_data;
      if (w_ier_wr)          r_ier        <= data_in[2:0];

      // Set wins over the clear-on-read.
      r_err_framing <= (r_err_framing & ~w_lsr_rd) | w_ev_framing;
      r_err_parity  <= (r_err_parity  & ~w_lsr_rd) | w_ev_parity;
      r_err_start   <= (r_err_start   & ~w_lsr_rd) | w_ev_start;
      r_overrun     <= (r_overrun     & ~w_esr_wr) | w_ev_overrun;
      r_err_cnt     <= w_cnt_next;

      irq <= (w_iir_code != IIR_NONE);
    end
  end

endmodule

// File: tb/tb_uart_line_status_irq.sv
module tb_uart_line_status_irq;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [15:0] A_IER = 16'h0001;
  localparam logic [15:0] A_IIR = 16'h0002;
  localparam logic [15:0] A_LSR = 16'h0004;
  localparam logic [15:0] A_ESR = 16'h0005;

  logic        m_clk;
  logic        reset;
  logic [15:0] address;
  logic        rd_en, wr_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out_reg;
  logic        FIFO_EN, wr_full_tx, wr_full_RX, rd_empty_RX, trigger_RX;
  logic        rx_push, start_bit_error, parity_bit_error, framing_stop_error;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [2:0] m_ier;
  logic       m_fr, m_pa, m_st, m_ovr;
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_irq;

  uart_line_status_irq #(.ERR_CNT_W(CW)) dut (
    .m_clk(m_clk), .reset(reset), .address(address), .rd_en(rd_en), .wr_en(wr_en),
    .data_in(data_in), .data_out_reg(data_out_reg), .FIFO_EN(FIFO_EN),
    .wr_full_tx(wr_full_tx), .wr_full_RX(wr_full_RX), .rd_empty_RX(rd_empty_RX),
    .trigger_RX(trigger_RX), .rx_push(rx_push), .start_bit_error(start_bit_error),
    .parity_bit_error(parity_bit_error), .framing_stop_error(framing_stop_error),
    .irq(irq)
  );

  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  function automatic logic [2:0] model_code();
    bit ls, rxd, txr;
    ls  = m_ier[2] && (m_fr || m_pa || m_st || m_ovr);
    rxd = m_ier[0] && (FIFO_EN ? trigger_RX : !rd_empty_RX);
    txr = m_ier[1] && !wr_full_tx;
    if (ls)       return 3'b110;
    else if (rxd) return 3'b100;
    else if (txr) return 3'b010;
    return 3'b001;
  endfunction

  // One clock: inputs already driven; advance the model, clear strobes.
  task automatic step();
    logic [7:0] rd_val;
    bit rd_hit, irq_nxt, ev_fr, ev_pa, ev_st, ev_ov;
    irq_nxt = (model_code() != 3'b001);
    ev_fr = rx_push && framing_stop_error;
    ev_pa = rx_push && parity_bit_error;
    ev_st = rx_push && start_bit_error;
    ev_ov = rx_push && wr_full_RX;
    rd_hit = 1'b1;
    rd_val = 8'h00;
    case (address)
      A_IER:   rd_val = {5'd0, m_ier};
      A_IIR:   rd_val = {5'd0, model_code()};
      A_LSR:   rd_val = {m_st | ev_st, m_pa | ev_pa, m_fr | ev_fr,
                         trigger_RX, wr_full_RX, rd_empty_RX, wr_full_tx, FIFO_EN};
      A_ESR:   rd_val = {7'(m_cnt), m_ovr};
      default: rd_hit = 1'b0;
    endcase
    @(posedge m_clk);
    if (reset) begin
      m_ier = 3'b000; m_fr = 1'b0; m_pa = 1'b0; m_st = 1'b0; m_ovr = 1'b0;
      m_cnt = 0; m_dout = 8'h00; m_irq = 1'b0;
    end else begin
      if (rd_en && rd_hit) m_dout = rd_val;
      if (rd_en && address == A_LSR) begin m_fr = 1'b0; m_pa = 1'b0; m_st = 1'b0; end
      m_fr = m_fr | ev_fr;
      m_pa = m_pa | ev_pa;
      m_st = m_st | ev_st;
      if (wr_en && address == A_ESR) begin m_cnt = 0; m_ovr = 1'b0; end
      if (ev_ov) m_ovr = 1'b1;
      if (ev_fr || ev_pa || ev_st || ev_ov) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (wr_en && address == A_IER) m_ier = data_in[2:0];
      m_irq = irq_nxt;
    end
    @(negedge m_clk);
    rd_en = 1'b0; wr_en = 1'b0; rx_push = 1'b0;
    start_bit_error = 1'b0; parity_bit_error = 1'b0; framing_stop_error = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    address = a; rd_en = 1'b1; step();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    address = a; data_in = d; wr_en = 1'b1; step();
  endtask

  task automatic do_push(input bit fr, input bit pa, input bit st);
    rx_push = 1'b1; framing_stop_error = fr; parity_bit_error = pa; start_bit_error = st;
    step();
  endtask

  task automatic set_live_default();
    FIFO_EN = 1'b1; wr_full_tx = 1'b1; rd_empty_RX = 1'b0; wr_full_RX = 1'b0; trigger_RX = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    n_total++; if (data_out_reg !== 8'h00) $display("FAIL reset_dout: got %h want 00", data_out_reg); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    do_read(A_IER);
    n_total++; if (data_out_reg !== 8'h00) $display("FAIL reset_ier: got %h want 00", data_out_reg); else n_pass++;
  endtask

  task automatic test_lsr_live();
    set_live_default();
    step();
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h13) $display("FAIL lsr_live: got %h want 13", data_out_reg); else n_pass++;
  endtask

  task automatic test_sticky();
    do_push(1'b0, 1'b1, 1'b0);
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h53) $display("FAIL sticky_set: got %h want 53", data_out_reg); else n_pass++;
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h13) $display("FAIL sticky_clear: got %h want 13", data_out_reg); else n_pass++;
    parity_bit_error = 1'b1; step();
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h13) $display("FAIL sticky_nopush: got %h want 13", data_out_reg); else n_pass++;
  endtask

  task automatic test_irq_ls();
    do_write(A_IER, 8'h04);
    do_push(1'b1, 1'b0, 1'b0);
    n_total++; if (irq !== 1'b0) $display("FAIL irq_ls_lag: got %b want 0", irq); else n_pass++;
    step();
    n_total++; if (irq !== 1'b1) $display("FAIL irq_ls_rise: got %b want 1", irq); else n_pass++;
    do_read(A_IIR);
    n_total++; if (data_out_reg !== 8'h06) $display("FAIL irq_ls_iir: got %h want 06", data_out_reg); else n_pass++;
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h33) $display("FAIL irq_ls_lsr: got %h want 33", data_out_reg); else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL irq_ls_hold: got %b want 1", irq); else n_pass++;
    step();
    n_total++; if (irq !== 1'b0) $display("FAIL irq_ls_fall: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_priority();
    do_write(A_IER, 8'h07);
    wr_full_tx = 1'b0; trigger_RX = 1'b1; FIFO_EN = 1'b1;
    do_push(1'b1, 1'b0, 1'b0);
    do_read(A_IIR);
    n_total++; if (data_out_reg !== 8'h06) $display("FAIL prio_ls: got %h want 06", data_out_reg); else n_pass++;
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h31) $display("FAIL prio_lsr: got %h want 31", data_out_reg); else n_pass++;
    do_read(A_IIR);
    n_total++; if (data_out_reg !== 8'h04) $display("FAIL prio_rxd: got %h want 04", data_out_reg); else n_pass++;
    trigger_RX = 1'b0;
    do_read(A_IIR);
    n_total++; if (data_out_reg !== 8'h02) $display("FAIL prio_txr: got %h want 02", data_out_reg); else n_pass++;
    FIFO_EN = 1'b0; rd_empty_RX = 1'b0;
    do_read(A_IIR);
    n_total++; if (data_out_reg !== 8'h04) $display("FAIL prio_rxd_nofifo: got %h want 04", data_out_reg); else n_pass++;
    rd_empty_RX = 1'b1; wr_full_tx = 1'b1;
    do_read(A_IIR);
    n_total++; if (data_out_reg !== 8'h01) $display("FAIL prio_none: got %h want 01", data_out_reg); else n_pass++;
    step();
    n_total++; if (irq !== 1'b0) $display("FAIL prio_irq_low: got %b want 0", irq); else n_pass++;
    do_write(A_IER, 8'h00);
    set_live_default();
    step();
  endtask

  task automatic test_set_wins();
    address = A_LSR; rd_en = 1'b1;
    rx_push = 1'b1; parity_bit_error = 1'b1;
    step();
    n_total++; if (data_out_reg !== 8'h53) $display("FAIL setwin_rd: got %h want 53", data_out_reg); else n_pass++;
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h53) $display("FAIL setwin_kept: got %h want 53", data_out_reg); else n_pass++;
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h13) $display("FAIL setwin_clear: got %h want 13", data_out_reg); else n_pass++;
  endtask

  task automatic test_counter();
    do_write(A_ESR, 8'h00);
    for (int i = 0; i < 5; i++) do_push(i[0], !i[0], i == 4);
    do_read(A_ESR);
    n_total++; if (data_out_reg !== 8'h06) $display("FAIL cnt_sat: got %h want 06", data_out_reg); else n_pass++;
    wr_full_RX = 1'b1;
    do_push(1'b0, 1'b0, 1'b0);
    wr_full_RX = 1'b0;
    do_read(A_ESR);
    n_total++; if (data_out_reg !== 8'h07) $display("FAIL cnt_ovr: got %h want 07", data_out_reg); else n_pass++;
    do_read(A_ESR);
    n_total++; if (data_out_reg !== 8'h07) $display("FAIL cnt_rd_noclr: got %h want 07", data_out_reg); else n_pass++;
    address = A_ESR; wr_en = 1'b1; data_in = 8'hA5;
    rx_push = 1'b1; parity_bit_error = 1'b1;
    step();
    do_read(A_ESR);
    n_total++; if (data_out_reg !== 8'h02) $display("FAIL cnt_clr_event: got %h want 02", data_out_reg); else n_pass++;
    do_write(A_ESR, 8'h00);
    do_read(A_ESR);
    n_total++; if (data_out_reg !== 8'h00) $display("FAIL cnt_clr: got %h want 00", data_out_reg); else n_pass++;
    do_read(A_LSR);
  endtask

  task automatic test_rw_same();
    address = A_IER; rd_en = 1'b1; wr_en = 1'b1; data_in = 8'hFD;
    step();
    n_total++; if (data_out_reg !== 8'h00) $display("FAIL rw_old: got %h want 00", data_out_reg); else n_pass++;
    do_read(A_IER);
    n_total++; if (data_out_reg !== 8'h05) $display("FAIL rw_new: got %h want 05", data_out_reg); else n_pass++;
  endtask

  task automatic test_unmapped();
    do_read(16'h0003);
    n_total++; if (data_out_reg !== 8'h05) $display("FAIL unmapped_hold: got %h want 05", data_out_reg); else n_pass++;
    do_write(A_LSR, 8'hFF);
    do_write(A_IIR, 8'hFF);
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h13) $display("FAIL ro_write: got %h want 13", data_out_reg); else n_pass++;
    do_write(A_IER, 8'h00);
  endtask

  task automatic test_reset_mid();
    do_write(A_IER, 8'h07);
    do_push(1'b1, 1'b1, 1'b1);
    reset = 1'b1; address = A_LSR; rd_en = 1'b1; rx_push = 1'b1; start_bit_error = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if (data_out_reg !== 8'h00) $display("FAIL rstmid_dout: got %h want 00", data_out_reg); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b want 0", irq); else n_pass++;
    do_read(A_LSR);
    n_total++; if (data_out_reg !== 8'h13) $display("FAIL rstmid_lsr: got %h want 13", data_out_reg); else n_pass++;
    do_read(A_ESR);
    n_total++; if (data_out_reg !== 8'h00) $display("FAIL rstmid_esr: got %h want 00", data_out_reg); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] addrs [5];
    addrs[0] = A_IER; addrs[1] = A_IIR; addrs[2] = A_LSR; addrs[3] = A_ESR; addrs[4] = 16'h0003;
    for (int i = 0; i < 400; i++) begin
      reset              = ($urandom_range(0, 99) == 0);
      address            = addrs[$urandom_range(0, 4)];
      rd_en              = ($urandom_range(0, 1) == 1);
      wr_en              = ($urandom_range(0, 4) == 0);
      data_in            = 8'($urandom);
      FIFO_EN            = 1'($urandom);
      wr_full_tx         = 1'($urandom);
      wr_full_RX         = ($urandom_range(0, 3) == 0);
      rd_empty_RX        = 1'($urandom);
      trigger_RX         = 1'($urandom);
      rx_push            = ($urandom_range(0, 2) == 0);
      start_bit_error    = ($urandom_range(0, 5) == 0);
      parity_bit_error   = ($urandom_range(0, 5) == 0);
      framing_stop_error = ($urandom_range(0, 5) == 0);
      step();
      n_total++;
      if (data_out_reg !== m_dout) $display("FAIL rand_dout[%0d]: got %h want %h", i, data_out_reg, m_dout);
      else n_pass++;
      n_total++;
      if (irq !== m_irq) $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, m_irq);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = 16'h0000; rd_en = 1'b0; wr_en = 1'b0; data_in = 8'h00;
    FIFO_EN = 1'b0; wr_full_tx = 1'b0; wr_full_RX = 1'b0; rd_empty_RX = 1'b1; trigger_RX = 1'b0;
    rx_push = 1'b0; start_bit_error = 1'b0; parity_bit_error = 1'b0; framing_stop_error = 1'b0;
    m_ier = 3'b000; m_fr = 1'b0; m_pa = 1'b0; m_st = 1'b0; m_ovr = 1'b0;
    m_cnt = 0; m_dout = 8'h00; m_irq = 1'b0;
    @(negedge m_clk);
    test_reset();
    test_lsr_live();
    test_sticky();
    test_irq_ls();
    test_priority();
    test_set_wins();
    test_counter();
    test_rw_same();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
